hack_pc_fetch: RTL and testbench

Program-counter and instruction-fetch sequencer for the multi-cycle Hack CPU. It holds the PC and runs a req/ack fetch handshake with instruction ROM. It latches each fetched instruction for the decode/ALU datapath, then picks the next PC from the ALU flags. The jump target is the A register contents, i.e. the registered result of the A-input 16-bit select (instruction vs ALU out).

---
 rtl/hack_pc_fetch.sv | 97 +++++++++
 tb/tb_hack_pc_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_pc_fetch.sv
// Program counter and req/ack instruction-fetch sequencer for the multi-cycle Hack CPU.
// Latches each fetched instruction, then picks the next PC from the ALU flags and A register.
module hack_pc_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        fetch_req,
   output logic [15:0] pc,
   input  logic        fetch_ack,
   input  logic [15:0] inst_in,
   output logic [15:0] inst_out,
   output logic        inst_valid,
   input  logic [15:0] a_val,
   input  logic        alu_zr,
   input  logic        alu_ng,
   input  logic        exec_valid,
   output logic        halted,
   output logic [15:0] retired
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] inst_q;
   logic        inst_valid_q;
   logic        halted_q;
   logic [15:0] retired_q;

   logic        jump_take;
   logic        halt_hit;
   logic [15:0] pc_d;

   // Jump condition from the latched C-instruction's jump bits; A-instructions never jump.
   always_comb begin
      jump_take = inst_q[15] &
                  ((inst_q[2] & alu_ng) |
                   (inst_q[1] & alu_zr) |
                   (inst_q[0] & ~alu_ng & ~alu_zr));
      halt_hit  = jump_take && (inst_q[2:0] == 3'b111) && (a_val == pc_q);
      pc_d      = jump_take ? a_val : (pc_q + 16'd1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         inst_q       <= 16'h0000;
         inst_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         retired_q    <= 16'h0000;
      end else begin
         inst_valid_q <= 1'b0;
         case (state_q)
            ST_FETCH: begin
               if (fetch_ack) begin
                  inst_q       <= inst_in;
                  inst_valid_q <= 1'b1;
                  state_q      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_valid) begin
                  retired_q <= retired_q + 16'd1;
                  // An unconditional jump to itself can never make progress: stop fetching.
                  if (halt_hit) begin
                     halted_q <= 1'b1;
                     state_q  <= ST_HALT;
                  end else begin
                     pc_q    <= pc_d;
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

   assign fetch_req  = (state_q == ST_FETCH) & ~reset;
   assign pc         = pc_q;
   assign inst_out   = inst_q;
   assign inst_valid = inst_valid_q;
   assign halted     = halted_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_hack_pc_fetch.sv
// Directed self-checking bench for hack_pc_fetch: one task per scenario, inline comparisons.
module tb_hack_pc_fetch;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic [15:0] pc;
   logic        fetch_ack;
   logic [15:0] inst_in;
   logic [15:0] inst_out;
   logic        inst_valid;
   logic [15:0] a_val;
   logic        alu_zr;
   logic        alu_ng;
   logic        exec_valid;
   logic        halted;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;
   int exp_ret  = 0;

   hack_pc_fetch #(.RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (fetch_req),
      .pc         (pc),
      .fetch_ack  (fetch_ack),
      .inst_in    (inst_in),
      .inst_out   (inst_out),
      .inst_valid (inst_valid),
      .a_val      (a_val),
      .alu_zr     (alu_zr),
      .alu_ng     (alu_ng),
      .exec_valid (exec_valid),
      .halted     (halted),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are observed and inputs changed 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch followed by execution in the first EXEC cycle.
   task automatic do_instr(input logic [15:0] inst, input logic [15:0] a,
                           input logic zr, input logic ng);
      fetch_ack  = 1'b1;
      inst_in    = inst;
      step();
      fetch_ack  = 1'b0;
      exec_valid = 1'b1;
      a_val      = a;
      alu_zr     = zr;
      alu_ng     = ng;
      step();
      exec_valid = 1'b0;
      alu_zr     = 1'b0;
      alu_ng     = 1'b0;
      exp_ret++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", fetch_req); end
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
      checks++; if (inst_out !== 16'h0000) begin failures++; $display("FAIL reset_inst got=%h exp=0000", inst_out); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_ival got=%b exp=0", inst_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halted); end
      checks++; if (retired !== 16'h0000) begin failures++; $display("FAIL reset_ret got=%h exp=0000", retired); end
      reset = 1'b0;
      #1;
      checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%b exp=1", fetch_req); end
      exp_ret = 0;
      $display("test_reset done");
   endtask

   task automatic test_sequential();
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL seq_pc0 got=%h exp=0000", pc); end
      fetch_ack = 1'b1;
      inst_in   = 16'h0005;
      step();
      fetch_ack = 1'b0;
      checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL seq_req_exec got=%b exp=0", fetch_req); end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL seq_ival got=%b exp=1", inst_valid); end
      checks++; if (inst_out !== 16'h0005) begin failures++; $display("FAIL seq_inst got=%h exp=0005", inst_out); end
      exec_valid = 1'b1;
      a_val      = 16'h0005;
      step();
      exec_valid = 1'b0;
      exp_ret++;
      checks++; if (pc !== 16'h0001) begin failures++; $display("FAIL seq_pc1 got=%h exp=0001", pc); end
      checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL seq_req_fetch got=%b exp=1", fetch_req); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL seq_ival_drop got=%b exp=0", inst_valid); end
      do_instr(16'h0007, 16'h0007, 1'b0, 1'b0);
      checks++; if (pc !== 16'h0002) begin failures++; $display("FAIL seq_pc2 got=%h exp=0002", pc); end
      checks++; if (inst_out !== 16'h0007) begin failures++; $display("FAIL seq_inst2 got=%h exp=0007", inst_out); end
      checks++; if (retired !== 16'd2) begin failures++; $display("FAIL seq_ret got=%h exp=0002", retired); end
      $display("test_sequential done pc=%h retired=%0d", pc, retired);
   endtask

   task automatic test_jump();
      do_instr(16'hE301, 16'h0040, 1'b0, 1'b0);
      checks++; if (pc !== 16'h0040) begin failures++; $display("FAIL jgt_taken got=%h exp=0040", pc); end
      do_instr(16'hE301, 16'h0040, 1'b0, 1'b1);
      checks++; if (pc !== 16'h0041) begin failures++; $display("FAIL jgt_not_taken got=%h exp=0041", pc); end
      do_instr(16'hE307, 16'h0040, 1'b1, 1'b0);
      checks++; if (pc !== 16'h0040) begin failures++; $display("FAIL jmp_zr got=%h exp=0040", pc); end
      do_instr(16'h6307, 16'h0099, 1'b1, 1'b0);
      checks++; if (pc !== 16'h0041) begin failures++; $display("FAIL ainst_nojump got=%h exp=0041", pc); end
      do_instr(16'hE304, 16'h0080, 1'b0, 1'b1);
      checks++; if (pc !== 16'h0080) begin failures++; $display("FAIL jlt_taken got=%h exp=0080", pc); end
      checks++; if (retired !== exp_ret[15:0]) begin failures++; $display("FAIL jump_ret got=%h exp=%h", retired, exp_ret[15:0]); end
      $display("test_jump done pc=%h", pc);
   endtask

   task automatic test_wrap();
      do_instr(16'hE307, 16'hFFFF, 1'b0, 1'b0);
      checks++; if (pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_load got=%h exp=ffff", pc); end
      do_instr(16'h0005, 16'h0000, 1'b0, 1'b0);
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL wrap_halt got=%b exp=0", halted); end
      $display("test_wrap done pc=%h", pc);
   endtask

   task automatic test_wait_states();
      // Spurious exec_valid with a would-be jump while waiting for the ROM.
      exec_valid = 1'b1;
      a_val      = 16'h0123;
      alu_zr     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (fetch_req !== 1'b1 || pc !== 16'h0000 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL wait_hold%0d got req=%b pc=%h ival=%b exp req=1 pc=0000 ival=0", i, fetch_req, pc, inst_valid);
         end
      end
      exec_valid = 1'b0;
      alu_zr     = 1'b0;
      fetch_ack  = 1'b1;
      inst_in    = 16'h0003;
      step();
      checks++; if (inst_valid !== 1'b1 || inst_out !== 16'h0003) begin
         failures++; $display("FAIL wait_latch got ival=%b inst=%h exp ival=1 inst=0003", inst_valid, inst_out);
      end
      inst_in = 16'h1234;
      step();
      fetch_ack = 1'b0;
      checks++; if (inst_valid !== 1'b0 || inst_out !== 16'h0003 || fetch_req !== 1'b0 || pc !== 16'h0000) begin
         failures++; $display("FAIL wait_spur_ack got ival=%b inst=%h req=%b pc=%h exp 0/0003/0/0000", inst_valid, inst_out, fetch_req, pc);
      end
      exec_valid = 1'b1;
      step();
      exec_valid = 1'b0;
      exp_ret++;
      checks++; if (pc !== 16'h0001 || fetch_req !== 1'b1) begin
         failures++; $display("FAIL wait_exec got pc=%h req=%b exp pc=0001 req=1", pc, fetch_req);
      end
      checks++; if (retired !== exp_ret[15:0]) begin failures++; $display("FAIL wait_ret got=%h exp=%h", retired, exp_ret[15:0]); end
      $display("test_wait_states done pc=%h", pc);
   endtask

   task automatic test_halt();
      do_instr(16'hE307, 16'h0012, 1'b0, 1'b0);
      checks++; if (pc !== 16'h0012) begin failures++; $display("FAIL halt_setup got=%h exp=0012", pc); end
      do_instr(16'hE302, 16'h0012, 1'b1, 1'b0);
      checks++; if (halted !== 1'b0 || fetch_req !== 1'b1 || pc !== 16'h0012) begin
         failures++; $display("FAIL jeq_self got halt=%b req=%b pc=%h exp 0/1/0012", halted, fetch_req, pc);
      end
      do_instr(16'hEA87, 16'h0012, 1'b1, 1'b0);
      checks++; if (halted !== 1'b1 || fetch_req !== 1'b0 || pc !== 16'h0012) begin
         failures++; $display("FAIL halt_entry got halt=%b req=%b pc=%h exp 1/0/0012", halted, fetch_req, pc);
      end
      checks++; if (retired !== exp_ret[15:0]) begin failures++; $display("FAIL halt_ret got=%h exp=%h", retired, exp_ret[15:0]); end
      fetch_ack  = 1'b1;
      exec_valid = 1'b1;
      a_val      = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (halted !== 1'b1 || fetch_req !== 1'b0 || pc !== 16'h0012 || retired !== exp_ret[15:0] || inst_valid !== 1'b0) begin
            failures++; $display("FAIL halt_hold%0d got halt=%b req=%b pc=%h ret=%h ival=%b", i, halted, fetch_req, pc, retired, inst_valid);
         end
      end
      fetch_ack  = 1'b0;
      exec_valid = 1'b0;
      $display("test_halt done pc=%h", pc);
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || fetch_req !== 1'b1 || pc !== 16'h0000) begin
         failures++; $display("FAIL rst_from_halt got halt=%b req=%b pc=%h exp 0/1/0000", halted, fetch_req, pc);
      end
      fetch_ack = 1'b1;
      inst_in   = 16'hE307;
      step();
      fetch_ack  = 1'b0;
      exec_valid = 1'b1;
      a_val      = 16'h0050;
      reset      = 1'b1;
      step();
      exec_valid = 1'b0;
      checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL rst_exec_req got=%b exp=0", fetch_req); end
      reset = 1'b0;
      #1;
      checks++; if (pc !== 16'h0000 || retired !== 16'h0000 || inst_out !== 16'h0000 || fetch_req !== 1'b1) begin
         failures++; $display("FAIL rst_exec got pc=%h ret=%h inst=%h req=%b exp 0000/0000/0000/1", pc, retired, inst_out, fetch_req);
      end
      fetch_ack = 1'b1;
      inst_in   = 16'hABCD;
      reset     = 1'b1;
      step();
      reset     = 1'b0;
      fetch_ack = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || inst_out !== 16'h0000 || pc !== 16'h0000 || fetch_req !== 1'b1 || halted !== 1'b0 || retired !== 16'h0000) begin
         failures++; $display("FAIL rst_fetch_ack got ival=%b inst=%h pc=%h req=%b halt=%b ret=%h", inst_valid, inst_out, pc, fetch_req, halted, retired);
      end
      step();
      checks++; if (inst_valid !== 1'b0 || fetch_req !== 1'b1) begin
         failures++; $display("FAIL rst_ack_discard got ival=%b req=%b exp 0/1", inst_valid, fetch_req);
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      reset      = 1'b1;
      fetch_ack  = 1'b0;
      inst_in    = 16'h0000;
      a_val      = 16'h0000;
      alu_zr     = 1'b0;
      alu_ng     = 1'b0;
      exec_valid = 1'b0;
      #1;
      test_reset();
      test_sequential();
      test_jump();
      test_wrap();
      test_wait_states();
      test_halt();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
